// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, opcodes and
// the default memory timeout.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WAIT  = 2'b01,
    ABORT = 2'b10
  } seqState_t;

  localparam logic [5:0] OP_RFORMAT = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  // Instructions that actually read rt as a source operand.
  function automatic logic usesRt(input logic [5:0] opcode);
    logic result;
    case (opcode)
      OP_RFORMAT, OP_SW, OP_BEQ: result = 1'b1;
      OP_LW, OP_J:               result = 1'b0;
      default:                   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Combinational load-use hazard detector between the load in EX and the
// instruction in ID.
module load_use_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic [5:0] idOpcode,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  output logic       loadUse
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRt == idRs);
  // An rt match only matters when the ID instruction reads rt.
  assign rtMatch = (exRt == idRt) && usesRt(idOpcode);
  assign loadUse = exMemRead && (exRt != 5'd0) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: hazard stalls, branch/jump flushes and data-memory wait
// handling with timeout abort, plus a saturating stall-cycle counter.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_jump,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        clr_stats,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic        mem_error,
  output logic [15:0] stall_cycles
);

  seqState_t   stateR;
  seqState_t   stateNext;
  logic [7:0]  waitCntR;
  logic [7:0]  waitCntNext;
  logic        memErrorR;
  logic        memErrorSet;
  logic [15:0] stallCntR;
  logic        loadUse;
  logic        timeoutHit;
  logic        freeze;

  load_use_detect uDetect (
    .idOpcode  (id_opcode),
    .idRs      (id_rs),
    .idRt      (id_rt),
    .exMemRead (ex_memRead),
    .exRt      (ex_rt),
    .loadUse   (loadUse)
  );

  // The final wait cycle is released so that exactly MEM_TIMEOUT cycles freeze.
  assign timeoutHit = (stateR == WAIT) && (waitCntR == 8'(MEM_TIMEOUT - 1)) && !mem_ready;
  assign freeze     = mem_req && !mem_ready && (stateR != ABORT) && !timeoutHit;

  // Next-state, wait counter and error-set decode.
  always_comb begin
    stateNext   = stateR;
    waitCntNext = waitCntR;
    memErrorSet = 1'b0;
    case (stateR)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stateNext = WAIT;
        end else begin
          stateNext = RUN;
        end
        waitCntNext = 8'd0;
      end
      WAIT: begin
        if (mem_ready) begin
          stateNext   = RUN;
          waitCntNext = 8'd0;
        end else if (timeoutHit) begin
          stateNext   = ABORT;
          waitCntNext = 8'd0;
          memErrorSet = 1'b1;
        end else begin
          stateNext   = WAIT;
          waitCntNext = waitCntR + 8'd1;
        end
      end
      ABORT: begin
        stateNext   = RUN;
        waitCntNext = 8'd0;
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = 8'd0;
      end
    endcase
  end

  // Priority-encoded pipeline control.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (loadUse) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR    <= RUN;
      waitCntR  <= 8'd0;
      memErrorR <= 1'b0;
    end else begin
      stateR    <= stateNext;
      waitCntR  <= waitCntNext;
      memErrorR <= memErrorR | memErrorSet;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntR <= 16'd0;
    end else if (clr_stats) begin
      stallCntR <= 16'd0;
    end else if (!pc_write && (stallCntR != 16'hFFFF)) begin
      stallCntR <= stallCntR + 16'd1;
    end else begin
      stallCntR <= stallCntR;
    end
  end

  assign mem_error    = memErrorR;
  assign stall_cycles = stallCntR;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed vectors push expected
// responses, a negedge monitor pops and compares them.
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  localparam logic [4:0] NORM = 5'b11000;  // {pc,ifidW,flush,bubble,hold}
  localparam logic [4:0] LU   = 5'b00010;
  localparam logic [4:0] BR   = 5'b11110;
  localparam logic [4:0] JMP  = 5'b11100;
  localparam logic [4:0] FRZ  = 5'b00001;

  typedef struct {
    logic [4:0]  ctl;
    logic        err;
    logic [15:0] stall;
    seqState_t   st;
    int          tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  idOpcode;
  logic [4:0]  idRs, idRt, exRt;
  logic        idJump, exMemRead, exBr, memReq, memReady, clrStats;
  logic        pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold, memError;
  logic [15:0] stallCycles;

  exp_t        q[$];
  logic [15:0] stallModel;
  int          tagCnt;
  int          nChecks;
  int          nPass;

  pipeline_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(idOpcode), .id_rs(idRs), .id_rt(idRt), .id_jump(idJump),
    .ex_memRead(exMemRead), .ex_rt(exRt), .ex_branch_taken(exBr),
    .mem_req(memReq), .mem_ready(memReady), .clr_stats(clrStats),
    .pc_write(pcWrite), .ifid_write(ifidWrite), .ifid_flush(ifidFlush),
    .idex_bubble(idexBubble), .pipe_hold(pipeHold), .mem_error(memError),
    .stall_cycles(stallCycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
  endtask

  // Monitor: compare the outputs of the cycle whose expectation is queued.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl", e.tag, 32'({pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold}), 32'(e.ctl));
      chk("mem_error", e.tag, 32'(memError), 32'(e.err));
      chk("stall_cycles", e.tag, 32'(stallCycles), 32'(e.stall));
      chk("state", e.tag, 32'(dut.stateR), 32'(e.st));
    end
  end

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic jmp, input logic mr, input logic [4:0] ert, input logic br,
                       input logic mreq, input logic mrdy, input logic clr,
                       input logic [4:0] ctl, input logic err, input seqState_t st, input bit doChk);
    exp_t e;
    @(posedge clk);
    #1;
    idOpcode = op; idRs = rs; idRt = rt; idJump = jmp; exMemRead = mr; exRt = ert;
    exBr = br; memReq = mreq; memReady = mrdy; clrStats = clr;
    tagCnt++;
    if (doChk) begin
      e.ctl = ctl; e.err = err; e.stall = stallModel; e.st = st; e.tag = tagCnt;
      q.push_back(e);
    end
    if (clr) stallModel = 16'd0;
    else if (!ctl[4] && stallModel != 16'hFFFF) stallModel = stallModel + 16'd1;
  endtask

  task automatic idle(input logic err);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, err, RUN, 1'b1);
  endtask

  initial begin
    nChecks = 0; nPass = 0; tagCnt = 0; stallModel = 16'd0;
    rst_n = 1'b0;
    idOpcode = 6'd0; idRs = 5'd0; idRt = 5'd0; idJump = 1'b0; exMemRead = 1'b0;
    exRt = 5'd0; exBr = 1'b0; memReq = 1'b0; memReady = 1'b0; clrStats = 1'b0;
    #2;
    chk("rst_state", 0, 32'(dut.stateR), 32'(RUN));
    chk("rst_stall", 0, 32'(stallCycles), 32'd0);
    chk("rst_err", 0, 32'(memError), 32'd0);
    chk("rst_ctl", 0, 32'({pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold}), 32'(NORM));
    #20 rst_n = 1'b1;

    // Hazard detection and control priority
    idle(1'b0);
    drive(6'd0,       5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, RUN, 1'b1);
    idle(1'b0);
    drive(6'b100011,  5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, RUN, 1'b1);
    drive(6'd0,       5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, RUN, 1'b1);
    drive(6'b101011,  5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, RUN, 1'b1);
    drive(6'b000100,  5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, RUN, 1'b1);
    drive(6'b000000,  5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, RUN, 1'b1);
    drive(6'b000000,  5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, RUN, 1'b1);
    drive(6'd0,       5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, BR,   1'b0, RUN, 1'b1);
    drive(6'b000010,  5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, JMP,  1'b0, RUN, 1'b1);
    drive(6'b000010,  5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU,   1'b0, RUN, 1'b1);
    idle(1'b0);
    drive(6'd0,       5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, LU,   1'b0, RUN, 1'b1);
    idle(1'b0);

    // Memory wait of three cycles; a taken branch is held off by the freeze
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 1'b0, RUN,  1'b1);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 1'b0, WAIT, 1'b1);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 1'b0, WAIT, 1'b1);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, BR,  1'b0, WAIT, 1'b1);
    idle(1'b0);

    // Never-ready access with MEM_TIMEOUT=4
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  1'b0, RUN,   1'b1);
    for (int i = 0; i < 3; i++)
      drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1'b0, WAIT, 1'b1);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b0, WAIT,  1'b1);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 1'b1, ABORT, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Clear, then saturate the stall counter
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NORM, 1'b1, RUN, 1'b1);
    for (int i = 0; i < 65534; i++)
      drive(6'd0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU, 1'b1, RUN, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(6'd0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU, 1'b1, RUN, 1'b1);
    idle(1'b1);

    // Asynchronous reset in the middle of a wait
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1'b1, RUN,  1'b1);
    drive(6'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1'b1, WAIT, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_state", tagCnt, 32'(dut.stateR), 32'(RUN));
    chk("arst_waitcnt", tagCnt, 32'(dut.waitCntR), 32'd0);
    chk("arst_err", tagCnt, 32'(memError), 32'd0);
    chk("arst_stall", tagCnt, 32'(stallCycles), 32'd0);
    chk("arst_ctl", tagCnt, 32'({pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold}), 32'(FRZ));
    #20;
    memReq = 1'b0;
    stallModel = 16'd0;
    rst_n = 1'b1;
    idle(1'b0);
    drive(6'd0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU, 1'b0, RUN, 1'b1);
    idle(1'b0);

    repeat (2) @(posedge clk);
    nChecks++;
    if (q.size() == 0) nPass++;
    else $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
